// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan logic.
// Holds the hex decode table, segment bit positions, blank codes and FSM states.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK_HI = 8'h00;
  localparam logic [7:0] SEG_BLANK_LO = 8'hFF;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble plus decimal point to an active-high {dp,g,f,e,d,c,b,a} pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern                = '0;
    pattern[SEG_G:SEG_A]   = SEG_TABLE[nibble];
    pattern[SEG_DP]        = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan sequencer with dead-time gaps and a
// frame-synchronous double-buffered load port.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_mask,
  input  logic [7:0]  load_dp,
  output logic        load_ready,
  output logic [2:0]  which,
  output logic [7:0]  seg,
  output logic        enable,
  output logic        frame_done
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(CLK_DIV - DEAD_CYCLES - 1);
  localparam logic [7:0]       BLANK    = SEG_ACTIVE_LOW ? SEG_BLANK_LO : SEG_BLANK_HI;
  localparam bit               HAS_GAP  = (DEAD_CYCLES > 0);

  function automatic logic [7:0] apply_polarity(input logic [7:0] pat);
    return SEG_ACTIVE_LOW ? ~pat : pat;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [2:0]       which_q;
  scan_state_e      state_q;

  logic [31:0]      sh_data;
  logic [7:0]       sh_mask;
  logic [7:0]       sh_dp;
  logic [31:0]      pd_data;
  logic [7:0]       pd_mask;
  logic [7:0]       pd_dp;
  logic             pend_full;
  logic             frame_done_q;

  logic             slot_end;
  logic             frame_end;
  logic             accept;
  logic [7:0]       dec_pat;
  logic             lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (which_q == 3'd7);
  assign accept    = load_valid && !pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      which_q <= '0;
    end else if (slot_end) begin
      cnt     <= '0;
      which_q <= which_q + 3'd1;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Dead time occupies the tail of every slot so the next digit's anodes never
  // overlap the previous digit's segment pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SHOW;
    end else begin
      case (state_q)
        SHOW:    if (HAS_GAP && (cnt == CNT_GAP)) state_q <= GAP;
        GAP:     if (slot_end) state_q <= SHOW;
        default: state_q <= SHOW;
      endcase
    end
  end

  // Pending buffer fills from the load port; it drains into the shadow copy
  // only on the frame boundary, so one frame never mixes old and new contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full <= 1'b0;
      pd_data   <= '0;
      pd_mask   <= '0;
      pd_dp     <= '0;
      sh_data   <= '0;
      sh_mask   <= '0;
      sh_dp     <= '0;
    end else if (frame_end && pend_full) begin
      sh_data   <= pd_data;
      sh_mask   <= pd_mask;
      sh_dp     <= pd_dp;
      pend_full <= 1'b0;
    end else if (accept) begin
      pd_data   <= load_data;
      pd_mask   <= load_mask;
      pd_dp     <= load_dp;
      pend_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
    end
  end

  seg_hex_decode u_dec (
    .nibble  (sh_data[{which_q, 2'b00} +: 4]),
    .dp      (sh_dp[which_q]),
    .pattern (dec_pat)
  );

  assign lit        = (state_q == SHOW) && sh_mask[which_q];
  assign enable     = lit;
  assign seg        = lit ? apply_polarity(dec_pat) : BLANK;
  assign which      = which_q;
  assign load_ready = !pend_full;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-indexed reference model predicts
// each cycle's outputs, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int C1 = 4;
  localparam int D1 = 1;
  localparam int C2 = 4;
  localparam int D2 = 0;

  typedef struct packed {
    logic [2:0] which;
    logic       en;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  localparam logic [7:0] TBL [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        lv1, lv2;
  logic [31:0] ld1, ld2;
  logic [7:0]  lm1, lm2, lp1, lp2;
  logic        rdy1, rdy2, en1, en2, fd1, fd2;
  logic [2:0]  wh1, wh2;
  logic [7:0]  seg1, seg2;

  int errors = 0;
  int checks = 0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(C1), .DEAD_CYCLES(D1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1), .load_mask(lm1),
    .load_dp(lp1), .load_ready(rdy1), .which(wh1), .seg(seg1), .enable(en1),
    .frame_done(fd1)
  );

  seg_scan_ctrl #(.CLK_DIV(C2), .DEAD_CYCLES(D2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2), .load_mask(lm2),
    .load_dp(lp2), .load_ready(rdy2), .which(wh2), .seg(seg2), .enable(en2),
    .frame_done(fd2)
  );

  // k = clock edges since reset release; everything follows from k and the shown contents.
  function automatic exp_t calc(int k, int c, int dd, bit al, logic [31:0] d,
                                logic [7:0] m, logic [7:0] p, bit pf);
    exp_t e;
    int w, pos;
    logic [7:0] pat;
    w   = (k / c) % 8;
    pos = k % c;
    e.which = 3'(w);
    e.en    = !((dd > 0) && (pos >= c - dd)) && m[w];
    pat     = TBL[d[4*w +: 4]] | (p[w] ? 8'h80 : 8'h00);
    if (!e.en) pat = 8'h00;
    e.seg   = al ? ~pat : pat;
    e.fd    = (k > 0) && ((k % (8 * c)) == 0);
    e.rdy   = !pf;
    return e;
  endfunction

  int          k1 = 0, k2 = 0;
  logic [31:0] sd1 = '0, pd1 = '0, sd2 = '0, pd2 = '0;
  logic [7:0]  sm1 = '0, pm1 = '0, sp1 = '0, pp1 = '0;
  logic [7:0]  sm2 = '0, pm2 = '0, sp2 = '0, pp2 = '0;
  bit          pf1 = 0, pf2 = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      k1 = 0; sd1 = '0; sm1 = '0; sp1 = '0; pf1 = 0;
      k2 = 0; sd2 = '0; sm2 = '0; sp2 = '0; pf2 = 0;
      q1.delete(); q2.delete();
    end else begin
      if (((k1 + 1) % (8 * C1)) == 0 && pf1) begin
        sd1 = pd1; sm1 = pm1; sp1 = pp1; pf1 = 0;
      end else if (lv1 && !pf1) begin
        pd1 = ld1; pm1 = lm1; pp1 = lp1; pf1 = 1;
      end
      k1++;
      if (((k2 + 1) % (8 * C2)) == 0 && pf2) begin
        sd2 = pd2; sm2 = pm2; sp2 = pp2; pf2 = 0;
      end else if (lv2 && !pf2) begin
        pd2 = ld2; pm2 = lm2; pp2 = lp2; pf2 = 1;
      end
      k2++;
    end
    q1.push_back(calc(k1, C1, D1, 1'b0, sd1, sm1, sp1, pf1));
    q2.push_back(calc(k2, C2, D2, 1'b1, sd2, sm2, sp2, pf2));
  end

  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{which: wh1, en: en1, seg: seg1, fd: fd1, rdy: rdy1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut1_out t=%0t got which=%0d en=%0b seg=%02h fd=%0b rdy=%0b want which=%0d en=%0b seg=%02h fd=%0b rdy=%0b",
                 $time, a.which, a.en, a.seg, a.fd, a.rdy, e.which, e.en, e.seg, e.fd, e.rdy);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = '{which: wh2, en: en2, seg: seg2, fd: fd2, rdy: rdy2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut2_out t=%0t got which=%0d en=%0b seg=%02h fd=%0b rdy=%0b want which=%0d en=%0b seg=%02h fd=%0b rdy=%0b",
                 $time, a.which, a.en, a.seg, a.fd, a.rdy, e.which, e.en, e.seg, e.fd, e.rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout got=none want=event", name);
  endtask

  task automatic do_load1(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
    logic r;
    int n;
    @(posedge clk); #1;
    lv1 = 1'b1; ld1 = d; lm1 = m; lp1 = p;
    for (n = 0; n < 200; n++) begin
      @(negedge clk); r = rdy1;
      @(posedge clk);
      if (r) break;
    end
    #1 lv1 = 1'b0; ld1 = $urandom; lm1 = 8'($urandom); lp1 = 8'($urandom);
    if (n == 200) timeout("load1_accept");
  endtask

  task automatic do_load2(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
    logic r;
    int n;
    @(posedge clk); #1;
    lv2 = 1'b1; ld2 = d; lm2 = m; lp2 = p;
    for (n = 0; n < 200; n++) begin
      @(negedge clk); r = rdy2;
      @(posedge clk);
      if (r) break;
    end
    #1 lv2 = 1'b0; ld2 = $urandom; lm2 = 8'($urandom); lp2 = 8'($urandom);
    if (n == 200) timeout("load2_accept");
  endtask

  task automatic wait_which1(input logic [2:0] v);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wh1 == v) break;
    end
    if (n == 100) timeout("wait_which");
  endtask

  task automatic wait_fd1();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (fd1) break;
    end
    if (n == 100) timeout("wait_frame_done");
  endtask

  initial begin
    rst = 1'b0;
    lv1 = 1'b0; ld1 = '0; lm1 = '0; lp1 = '0;
    lv2 = 1'b0; ld2 = '0; lm2 = '0; lp2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    fork
      begin
        wait_which1(3'd3);
        do_load1(32'h1234_5678, 8'hFF, 8'h00);
        do_load1(32'hABCD_EF01, 8'hFF, 8'h00);
        do_load1(32'h9E0C_B5A8, 8'h0F, 8'h01);
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 40)) @(posedge clk);
          do_load1($urandom, 8'($urandom), 8'($urandom));
        end
      end
      begin
        do_load2(32'h0000_0000, 8'hFF, 8'h00);
        repeat (100) @(posedge clk);
        do_load2(32'h0000_0000, 8'h00, 8'h00);
      end
    join

    // Async reset mid-frame with a load sitting in the pending buffer.
    wait_fd1();
    do_load1($urandom, 8'hFF, 8'($urandom));
    wait_which1(3'd5);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_which", {5'd0, wh1}, 8'h00);
    chk("async_enable", {7'd0, en1}, 8'h00);
    chk("async_seg", seg1, 8'h00);
    chk("async_ready", {7'd0, rdy1}, 8'h01);
    chk("async_frame_done", {7'd0, fd1}, 8'h00);
    chk("async_seg_low", seg2, 8'hFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencer for the board's 8-digit multiplexed seven-segment display.
- Time-slices the digits with a programmable slot length and an anti-ghosting dead time.
- Accepts new display contents through a valid/ready load port. Loads take effect only at a frame boundary, so a frame never shows a mix of old and new data.
- Sits between the switch/data-select logic and the board pins `which`, `seg` and `enable`.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot. Must be at least 2 and greater than DEAD_CYCLES.
- DEAD_CYCLES, 2: cycles at the end of each slot with `enable` forced low. 0 means no gap.
- SEG_ACTIVE_LOW, 0: 1 inverts all 8 `seg` bits, including the blank code.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  requester offers new contents.
- load_data  in  32  8 hex nibbles. Digit i shows load_data[4i+3:4i].
- load_mask  in  8  per-digit enable. Bit i = 1 lights digit i.
- load_dp  in  8  per-digit decimal point.
- load_ready  out  1  pending buffer empty; a load is accepted this cycle.
- which  out  3  digit select, 0..7.
- seg  out  8  segments, ordered {dp,g,f,e,d,c,b,a}.
- enable  out  1  digit drive enable.
- frame_done  out  1  one-cycle pulse in the first cycle of digit 0 of each frame.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-frame. Reset values:
  - slot counter = 0; which = 0; state = SHOW.
  - shadow data, mask and dp = 0.
  - pending buffer empty; load_ready = 1.
  - enable = 0; seg = blank; frame_done = 0.
  - Any pending load is discarded.
- Slot counter:
  - counts 0..CLK_DIV-1 and wraps to 0.
  - The last count is the slot-end cycle. On that edge `which` increments, wrapping 7 to 0.
- FSM, states SHOW and GAP:
  - SHOW covers counts 0..CLK_DIV-DEAD_CYCLES-1. GAP covers the remaining counts.
  - SHOW goes to GAP when count = CLK_DIV-DEAD_CYCLES-1, if DEAD_CYCLES > 0.
  - GAP goes to SHOW on the slot-end edge.
  - With DEAD_CYCLES = 0 the FSM stays in SHOW.
- Outputs:
  - In SHOW: enable = mask[which]. seg = decode(shadow nibble[which]) with bit7 = dp[which], but only when enable = 1; otherwise seg = blank.
  - In GAP: enable = 0 and seg = blank.
  - Blank is 0x00, or 0xFF when SEG_ACTIVE_LOW = 1.
  - enable and seg are combinational from registered state only. There is no input-to-output path.
- Decode table, active-high:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Load handshake:
  - load_ready = pending empty.
  - When load_valid && load_ready, capture data, mask and dp into the pending buffer. load_ready goes to 0 from the next cycle.
  - The requester holds load_valid and its data until accepted. Nothing is dropped.
- Frame boundary (slot-end edge with which = 7):
  - If pending is full, shadow <= pending and pending is cleared. Digit 0 of the new frame shows the new data. load_ready = 1 in the next cycle.
  - A load accepted on the boundary cycle itself, with pending already empty, goes to pending and is applied at the following boundary.
- frame_done is registered and goes high in the cycle after the boundary edge, for exactly 1 cycle.
- All widths are fixed. The slot counter is $clog2(CLK_DIV) bits wide.

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry segment decode constant table;
  - segment bit-position constants;
  - blank code constants;
  - the FSM state enum {SHOW, GAP}.
- One natural combinational sub-module: seg_hex_decode, taking nibble and dp and producing the 8-bit pattern before polarity inversion.

Test Plan (CLK_DIV=4, DEAD_CYCLES=1 unless noted):
- Reset check: assert rst=0 -> which=0, enable=0, seg=0x00, load_ready=1, frame_done=0. Release -> which steps 0,1,...,7,0 every 4 cycles; enable stays 0 because the mask is 0.
- First load: during digit 3, load 0x12345678 / mask 0xFF / dp 0x00 -> load_ready=0 next cycle; display blank until wrap; frame_done pulses; then per slot: digit 0 seg=0x7F, digit 1 seg=0x07, ..., digit 7 seg=0x06; enable pattern per slot 1,1,1,0; load_ready=1 after the boundary.
- Back-pressure: hold a second load_valid (0xABCDEF01) while pending is full -> not accepted until load_ready=1; frame N shows the first value, frame N+1 shows the second; no data lost.
- Mask/dp: mask 0x0F, dp 0x01 -> digits 4-7 enable=0 and seg=0x00; digit 0 seg has bit7=1.
- Async reset mid-frame: drop rst at which=5 with a pending load -> outputs reach reset values without a clock edge; after release, the pending load is never displayed.
- Polarity (SEG_ACTIVE_LOW=1, DEAD_CYCLES=0): load all zeros, mask 0xFF -> seg=0xC0 on every digit, enable=1 continuously; mask 0x00 -> seg=0xFF.
